// File: rtl/serial_feeder_pkg.sv
// Shared definitions for the serial bit feeder.
//   state_t        : FSM state encoding (IDLE, SHIFT, GAP)
//   DEF_*          : default parameter values for serial_bit_feeder
//   gap_cnt_width  : width of the gap counter, never less than one bit
package serial_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_MSB_FIRST  = 1;
    localparam int DEF_GAP_CYCLES = 1;

    function automatic int gap_cnt_width(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front stage for the two-consecutive-ones Mealy detector.
// A word accepted on the load handshake is played out one bit per clock on w,
// followed by GAP_CYCLES forced-zero cycles so the detector settles between
// frames. w is registered so the detector's combinational output sees a
// glitch-free input.
//
// Ports:
//   clk         clock, all state changes on posedge
//   Resetn      asynchronous active-low reset
//   load_valid  upstream offers a word
//   load_ready  block can accept a word (IDLE only, decoded from state)
//   data_in     word to serialize, sampled only on an accepted handshake
//   w           serial bit to the detector (registered)
//   w_valid     w carries a frame bit (registered)
//   busy        high in SHIFT or GAP (decoded from state)
//   done        one-cycle pulse with the last frame bit (registered)
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MSB_FIRST  = DEF_MSB_FIRST,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             Resetn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH);
    localparam int GCW = gap_cnt_width(GAP_CYCLES);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [BCW-1:0]   r_bitcnt;
    logic [GCW-1:0]   r_gapcnt;
    logic             r_w;
    logic             r_w_valid;
    logic             r_done;

    state_t           w_state_nxt;
    logic             w_accept;

    // Bit that leaves the word next, taken from the end selected by MSB_FIRST.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    // Word with its head bit removed, moving the following bit into the head.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_valid) begin
                    w_state_nxt = SHIFT;
                    w_accept    = 1'b1;
                end
            end
            SHIFT: begin
                if (r_bitcnt == '0)
                    w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (r_gapcnt == '0)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign load_ready = (r_state == IDLE);
    assign busy       = (r_state == SHIFT) || (r_state == GAP);

    assign w       = r_w;
    assign w_valid = r_w_valid;
    assign done    = r_done;

    // The first bit is registered onto w at the accepting edge, so r_shift
    // only ever holds the bits still to come; the bit counter names the
    // remaining bits after the one currently on w.
    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_gapcnt  <= '0;
            r_w       <= 1'b0;
            r_w_valid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_w       <= head_bit(data_in);
                        r_shift   <= drop_head(data_in);
                        r_bitcnt  <= BIT_LAST;
                        r_w_valid <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_bitcnt != '0) begin
                        r_w      <= head_bit(r_shift);
                        r_shift  <= drop_head(r_shift);
                        r_bitcnt <= r_bitcnt - BIT_ONE;
                        // Flag the last bit as it is placed on w.
                        r_done   <= (r_bitcnt == BIT_ONE);
                    end else begin
                        r_w       <= 1'b0;
                        r_w_valid <= 1'b0;
                        r_done    <= 1'b0;
                        r_gapcnt  <= GAP_LAST;
                    end
                end
                GAP: begin
                    if (r_gapcnt != '0)
                        r_gapcnt <= r_gapcnt - GAP_ONE;
                end
                default: begin
                    r_w       <= 1'b0;
                    r_w_valid <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (MSB-first with one gap cycle,
// LSB-first with no gap) share the same load stimulus. A reference model
// turns every accepted word into a queue of time-stamped expected bits; a
// monitor compares every cycle's outputs against that queue.
module tb_serial_bit_feeder;

    localparam int W = 8;

    typedef struct {
        int cyc;
        bit b;
        bit last;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         load_valid;
    logic [W-1:0] data_in;

    logic o_ready [2];
    logic o_w     [2];
    logic o_wv    [2];
    logic o_busy  [2];
    logic o_done  [2];

    exp_t q [2][$];
    int   free_at [2];
    int   cyc;
    int   total;
    int   bad;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(1)) u_msb (
        .clk(clk), .Resetn(rst_n), .load_valid(load_valid), .load_ready(o_ready[0]),
        .data_in(data_in), .w(o_w[0]), .w_valid(o_wv[0]), .busy(o_busy[0]), .done(o_done[0])
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0), .GAP_CYCLES(0)) u_lsb (
        .clk(clk), .Resetn(rst_n), .load_valid(load_valid), .load_ready(o_ready[1]),
        .data_in(data_in), .w(o_w[1]), .w_valid(o_wv[1]), .busy(o_busy[1]), .done(o_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit msb_of(input int d);
        return (d == 0);
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Reference model: a word accepted at edge e occupies cycles e..e+W-1
    // with its bits, then gap_of(d) zero cycles, then one idle cycle before
    // the next edge that may accept.
    initial begin
        cyc = 0;
        free_at[0] = 0;
        free_at[1] = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    if (load_valid && cyc >= free_at[d]) begin
                        for (int k = 0; k < W; k++) begin
                            exp_t e;
                            e.cyc  = cyc + k;
                            e.b    = msb_of(d) ? data_in[W-1-k] : data_in[k];
                            e.last = (k == W - 1);
                            q[d].push_back(e);
                        end
                        free_at[d] = cyc + W + gap_of(d) + 1;
                    end
                end
            end
        end
    end

    task automatic check_dut(input int d);
        logic [4:0] got;
        logic [4:0] exp;
        bit act;
        bit b;
        bit last;
        bit rdy;
        act  = 1'b0;
        b    = 1'b0;
        last = 1'b0;
        if (q[d].size() > 0 && q[d][0].cyc == cyc) begin
            act  = 1'b1;
            b    = q[d][0].b;
            last = q[d][0].last;
            void'(q[d].pop_front());
        end
        rdy = !rst_n || (cyc + 1 >= free_at[d]);
        got = {o_w[d], o_wv[d], o_done[d], o_ready[d], o_busy[d]};
        exp = {b, act, act & last, rdy, !rdy};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL outputs dut%0d cyc=%0d {w,w_valid,done,load_ready,busy} got=%b exp=%b",
                     d, cyc, got, exp);
        end
    endtask

    // Monitor
    initial begin
        total = 0;
        bad   = 0;
        forever begin
            @(negedge clk);
            check_dut(0);
            check_dut(1);
        end
    end

    function automatic bit all_idle();
        return (q[0].size() == 0) && (q[1].size() == 0) &&
               (cyc + 1 >= free_at[0]) && (cyc + 1 >= free_at[1]);
    endfunction

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (all_idle()) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL idle_timeout got=busy exp=idle within 100 cycles");
        end
    endtask

    task automatic send(input logic [W-1:0] word);
        @(negedge clk);
        #1;
        load_valid = 1'b1;
        data_in    = word;
        @(negedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = W'($urandom);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame of 8'b1011_0110.
        wait_idle();
        send(8'b1011_0110);
        wait_idle();

        // Held valid: 8'hFF accepted first, 8'h81 offered for every later frame.
        @(negedge clk);
        #1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        @(negedge clk);
        #1;
        data_in = 8'h81;
        repeat (25) @(negedge clk);
        #1;
        load_valid = 1'b0;
        wait_idle();

        // Load, then toggle valid and data while both are busy.
        send(8'h5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            load_valid = i[0];
            data_in    = W'($urandom);
        end
        load_valid = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of 8'hFF (fourth bit on w).
        send(8'hFF);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        free_at[0] = 0;
        free_at[1] = 0;
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle();
        send(8'h0F);
        wait_idle();

        // LSB-first word 8'b0000_0011 on both instances.
        send(8'b0000_0011);
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            load_valid = ($urandom_range(0, 3) != 0);
            data_in    = W'($urandom);
        end
        load_valid = 1'b0;
        wait_idle();

        total++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d pending exp=0/0", q[0].size(), q[1].size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front stage for the two-consecutive-ones Mealy detector. Accepts a WIDTH-bit word through a valid/ready handshake and presents it one bit per clock on `w`. It follows each frame with a programmable run of forced-zero gap cycles, so the detector returns to state A between frames. `w` is registered, which gives the downstream combinational Mealy output a glitch-free input.

## Interface
Parameters:
- `WIDTH`, 8: bits per frame; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 shifts `data_in[WIDTH-1]` first; 0 shifts `data_in[0]` first.
- `GAP_CYCLES`, 1: number of forced-zero cycles after each frame; legal range ≥ 0.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  upstream offers a word.
- `load_ready`  out  1  block can accept a word.
- `data_in`  in  WIDTH  word to serialize; sampled only on an accepted handshake.
- `w`  out  1  serial bit to the detector.
- `w_valid`  out  1  `w` carries a frame bit (high only in SHIFT).
- `busy`  out  1  high in SHIFT or GAP.
- `done`  out  1  one-cycle pulse, coincident with the last frame bit on `w`.

## Operation
- The FSM has three states: IDLE, SHIFT, GAP.
- **IDLE**
  - `load_ready`=1, `w`=0, `w_valid`=0.
  - On `load_valid && load_ready` at a posedge: the shift register loads `data_in`, the bit counter loads WIDTH−1, and the FSM goes to SHIFT.
- **SHIFT**
  - `w`=current bit (MSB or LSB end per `MSB_FIRST`); `w_valid`=1.
  - Each posedge shifts the register and decrements the counter.
  - When the counter is 0, `done`=1 in that cycle.
  - At the next edge: go to GAP if `GAP_CYCLES`>0, else go to IDLE.
- **GAP**
  - `w`=0, `w_valid`=0; the gap counter runs for `GAP_CYCLES` cycles, then the FSM goes to IDLE.
- `load_ready` is decoded from state and is 1 only in IDLE.
  - `load_valid` in SHIFT/GAP is ignored and does not stall.
  - Changes on `data_in` outside an accepted handshake have no effect.
- Counter widths:
  - Bit counter: `$clog2(WIDTH)`.
  - Gap counter: `$clog2(GAP_CYCLES+1)`, minimum 1 bit.
  - No wrap is permitted; the counters saturate at 0 only through state exit.
- Reset (asynchronous, any time, including mid-frame):
  - State=IDLE; shift register, counters, `w`, `w_valid`, `done` = 0.
  - `busy`=0; `load_ready`=1.
  - A partial frame is discarded and is not resumed.

## Timing
- Handshake at edge T → first bit on `w` during cycle T+1 → last bit during T+WIDTH, with `done`=1 during T+WIDTH.
- Gap zeros occupy T+WIDTH+1 … T+WIDTH+GAP_CYCLES.
- IDLE (`load_ready`=1) begins at T+WIDTH+GAP_CYCLES+1, so the earliest next handshake is at the end of that cycle.
- Throughput: one frame per WIDTH+GAP_CYCLES+1 cycles with `load_valid` held high.
- All outputs except `load_ready` and `busy` are registered; `load_ready` and `busy` are combinational from state only, with no input-to-output paths.

## Structure
- Package `serial_feeder_pkg` holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2);
  - default parameter constants.
- Single module, with no sub-module: one sequential always block (async reset) for state, counters and registers, plus one combinational next-state/decode block.

## Test plan
- **Basic MSB-first.** WIDTH=8, MSB_FIRST=1, GAP=1, load 8'b1011_0110 at T.
  - `w`=1,0,1,1,0,1,1,0 on T+1..T+8 with `w_valid`=1.
  - `done` at T+8; `w`=0 at T+9; `load_ready`=1 at T+10.
- **Back-to-back.** `load_valid` held high, words 8'hFF then 8'h81.
  - Second frame's first bit appears at T+11.
  - Exactly one gap zero plus one idle zero between frames; no bit lost.
- **Busy ignore.** Toggle `load_valid` and `data_in` during SHIFT.
  - Output sequence is unchanged; no second frame starts until IDLE.
- **Reset mid-frame.** Assert `Resetn`=0 asynchronously at bit 4 of 8'hFF.
  - `w`, `w_valid`, `busy` drop to 0 immediately; `load_ready`=1.
  - After release, a new load 8'h0F serializes correctly from its first bit.
- **LSB-first.** MSB_FIRST=0, load 8'b0000_0011.
  - `w`=1,1,0,0,0,0,0,0.
  - With the downstream detector attached, `z`=1 during the second bit only.
- **Zero gap.** GAP_CYCLES=0, two back-to-back loads.
  - IDLE immediately follows the last bit; frames are separated by exactly one `w`=0 cycle.
